// File: rtl/frame_bit_counter.sv
// Oversampled serial-frame bit sequencer: walks start, data, optional parity and
// stop slots, with a mid-bit sample pulse and a one-cycle frame-complete pulse.
module frame_bit_counter #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic       sr_clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       start,
    input  logic       clear,
    output logic       busy,
    output logic       sample_strobe,
    output logic [3:0] state,
    output logic       data_slot,
    output logic       parity_slot,
    output logic       stop_slot,
    output logic       finish
);

    localparam int FRAME_BITS = 1 + DATA_BITS + PARITY_EN + STOP_BITS;

    localparam logic [5:0] SAMPLE_LAST = 6'(OVERSAMPLE - 1);
    localparam logic [5:0] SAMPLE_MID  = 6'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] BIT_LAST    = 4'(FRAME_BITS - 1);
    localparam logic [3:0] DATA_LAST   = 4'(DATA_BITS);
    localparam logic [3:0] PARITY_IDX  = 4'(DATA_BITS + 1);
    localparam logic [3:0] STOP_FIRST  = 4'(1 + DATA_BITS + PARITY_EN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } fsm_t;

    fsm_t       fsm_q, fsm_d;
    logic [5:0] sample_cnt_q, sample_cnt_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;

    always_ff @(posedge sr_clk or negedge reset) begin
        if (!reset) begin
            fsm_q        <= IDLE;
            sample_cnt_q <= '0;
            bit_cnt_q    <= '0;
        end else begin
            fsm_q        <= fsm_d;
            sample_cnt_q <= sample_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
        end
    end

    always_comb begin
        fsm_d        = fsm_q;
        sample_cnt_d = sample_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        if (clear) begin
            fsm_d        = IDLE;
            sample_cnt_d = '0;
            bit_cnt_d    = '0;
        end else begin
            unique case (fsm_q)
                IDLE: begin
                    if (start && enable) begin
                        fsm_d        = COUNT;
                        sample_cnt_d = '0;
                        bit_cnt_d    = '0;
                    end
                end
                COUNT: begin
                    if (enable) begin
                        if (sample_cnt_q == SAMPLE_LAST) begin
                            sample_cnt_d = '0;
                            // Last slot wraps into DONE instead of advancing the bit index.
                            if (bit_cnt_q == BIT_LAST) begin
                                fsm_d     = DONE;
                                bit_cnt_d = '0;
                            end else begin
                                bit_cnt_d = bit_cnt_q + 4'd1;
                            end
                        end else begin
                            sample_cnt_d = sample_cnt_q + 6'd1;
                        end
                    end
                end
                DONE: begin
                    fsm_d        = IDLE;
                    sample_cnt_d = '0;
                    bit_cnt_d    = '0;
                end
                default: begin
                    fsm_d        = IDLE;
                    sample_cnt_d = '0;
                    bit_cnt_d    = '0;
                end
            endcase
        end
    end

    // All outputs decode straight from registers so reset clears them immediately.
    logic in_count;
    assign in_count      = (fsm_q == COUNT);
    assign busy          = in_count;
    assign sample_strobe = in_count && enable && (sample_cnt_q == SAMPLE_MID);
    assign state         = in_count ? bit_cnt_q : 4'd0;
    assign data_slot     = in_count && (bit_cnt_q >= 4'd1) && (bit_cnt_q <= DATA_LAST);
    assign parity_slot   = in_count && (PARITY_EN != 0) && (bit_cnt_q == PARITY_IDX);
    assign stop_slot     = in_count && (bit_cnt_q >= STOP_FIRST);
    assign finish        = (fsm_q == DONE);

endmodule

// File: tb/tb_frame_bit_counter.sv
// Directed bench for frame_bit_counter: three parameterisations driven from shared
// inputs, each scenario task checking its own expected timing.
module tb_frame_bit_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       start;
    logic       clear;
    logic       busy          [3];
    logic       sample_strobe [3];
    logic [3:0] st            [3];
    logic       data_slot     [3];
    logic       parity_slot   [3];
    logic       stop_slot     [3];
    logic       finish        [3];

    int checks   = 0;
    int failures = 0;

    int db_t  [3] = '{8, 8, 5};
    int par_t [3] = '{0, 1, 0};

    // Results of the most recent run_frame call.
    int r_strobes, r_finish_at, r_nfin, r_err, r_par_state, r_stop_state;
    int r_first_state, r_busy1;
    int r_strobe_cyc [16];

    always #5 clk = ~clk;

    frame_bit_counter dut0 (
        .sr_clk(clk), .reset(rst_n), .enable(enable), .start(start), .clear(clear),
        .busy(busy[0]), .sample_strobe(sample_strobe[0]), .state(st[0]),
        .data_slot(data_slot[0]), .parity_slot(parity_slot[0]), .stop_slot(stop_slot[0]),
        .finish(finish[0])
    );

    frame_bit_counter #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .STOP_BITS(2)) dut1 (
        .sr_clk(clk), .reset(rst_n), .enable(enable), .start(start), .clear(clear),
        .busy(busy[1]), .sample_strobe(sample_strobe[1]), .state(st[1]),
        .data_slot(data_slot[1]), .parity_slot(parity_slot[1]), .stop_slot(stop_slot[1]),
        .finish(finish[1])
    );

    frame_bit_counter #(.DATA_BITS(5), .OVERSAMPLE(4), .PARITY_EN(0), .STOP_BITS(1)) dut2 (
        .sr_clk(clk), .reset(rst_n), .enable(enable), .start(start), .clear(clear),
        .busy(busy[2]), .sample_strobe(sample_strobe[2]), .state(st[2]),
        .data_slot(data_slot[2]), .parity_slot(parity_slot[2]), .stop_slot(stop_slot[2]),
        .finish(finish[2])
    );

    task automatic idle_all();
        clear  = 1'b1;
        start  = 1'b0;
        enable = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    // Starts a frame and watches DUT d cycle by cycle until it returns to IDLE.
    // Cycle 1 is the first COUNT cycle; enable is low for cycles drop_at..drop_at+drop_len-1.
    task automatic run_frame(input int d, input int drop_at, input int drop_len,
                             input bit start_in_done);
        int  cyc;
        int  s;
        bit  exp_data, exp_par, exp_stop;
        r_strobes = 0; r_finish_at = -1; r_nfin = 0; r_err = 0;
        r_par_state = -1; r_stop_state = -1; r_first_state = -1; r_busy1 = 0;
        for (int k = 0; k < 16; k++) r_strobe_cyc[k] = -1;
        start  = 1'b1;
        enable = 1'b1;
        @(negedge clk);
        cyc = 0;
        for (int i = 0; i < 1000; i++) begin
            cyc++;
            start  = 1'b0;
            enable = !(cyc >= drop_at && cyc < drop_at + drop_len);
            #1;
            s = int'(st[d]);
            if (cyc == 1) r_busy1 = int'(busy[d]);
            if (busy[d] === 1'b1) begin
                exp_data = (s >= 1) && (s <= db_t[d]);
                exp_par  = (par_t[d] != 0) && (s == db_t[d] + 1);
                exp_stop = (s >= 1 + db_t[d] + par_t[d]);
                if (data_slot[d] !== exp_data || parity_slot[d] !== exp_par ||
                    stop_slot[d] !== exp_stop) r_err++;
                if (parity_slot[d] === 1'b1 && r_par_state < 0) r_par_state = s;
                if (stop_slot[d] === 1'b1 && r_stop_state < 0) r_stop_state = s;
            end else if (st[d] !== 4'd0 || data_slot[d] !== 1'b0 ||
                         parity_slot[d] !== 1'b0 || stop_slot[d] !== 1'b0) begin
                r_err++;
            end
            if (!enable && (sample_strobe[d] !== 1'b0 || busy[d] !== 1'b1)) r_err++;
            if (sample_strobe[d] === 1'b1) begin
                if (r_strobes < 16) r_strobe_cyc[r_strobes] = cyc;
                if (r_strobes == 0) r_first_state = s;
                r_strobes++;
            end
            if (finish[d] === 1'b1) begin
                r_nfin++;
                r_finish_at = cyc;
                if (start_in_done) start = 1'b1;
            end else if (busy[d] !== 1'b1 && r_finish_at >= 0) begin
                break;
            end
            @(negedge clk);
        end
        start  = 1'b0;
        enable = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; start = 1'b0; clear = 1'b0;
        #2;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if ({busy[d], sample_strobe[d], st[d], data_slot[d], parity_slot[d],
                 stop_slot[d], finish[d]} !== 10'd0) begin
                failures++;
                $display("FAIL reset_outputs dut%0d got=%b exp=0", d,
                         {busy[d], sample_strobe[d], st[d], data_slot[d], parity_slot[d],
                          stop_slot[d], finish[d]});
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic test_default_frame();
        idle_all();
        run_frame(0, 0, 0, 1'b0);
        checks++;
        if (r_busy1 !== 1) begin failures++; $display("FAIL busy_next_cycle got=%0d exp=1", r_busy1); end
        checks++;
        if (r_strobe_cyc[0] !== 8) begin failures++; $display("FAIL first_strobe_cycle got=%0d exp=8", r_strobe_cyc[0]); end
        checks++;
        if (r_first_state !== 0) begin failures++; $display("FAIL first_strobe_state got=%0d exp=0", r_first_state); end
        checks++;
        if (r_strobes !== 10) begin failures++; $display("FAIL default_strobes got=%0d exp=10", r_strobes); end
        checks++;
        if (r_finish_at !== 161) begin failures++; $display("FAIL default_finish_cycle got=%0d exp=161", r_finish_at); end
        checks++;
        if (r_nfin !== 1 || r_err !== 0) begin
            failures++; $display("FAIL default_pulse_and_slots nfin=%0d err=%0d exp nfin=1 err=0", r_nfin, r_err);
        end
        $display("test_default_frame strobes=%0d finish_at=%0d", r_strobes, r_finish_at);
    endtask

    task automatic test_parity_frame();
        idle_all();
        run_frame(1, 0, 0, 1'b0);
        checks++;
        if (r_strobes !== 12) begin failures++; $display("FAIL parity_strobes got=%0d exp=12", r_strobes); end
        checks++;
        if (r_finish_at !== 193) begin failures++; $display("FAIL parity_finish_cycle got=%0d exp=193", r_finish_at); end
        checks++;
        if (r_par_state !== 9) begin failures++; $display("FAIL parity_slot_state got=%0d exp=9", r_par_state); end
        checks++;
        if (r_stop_state !== 10) begin failures++; $display("FAIL stop_slot_first got=%0d exp=10", r_stop_state); end
        checks++;
        if (r_err !== 0) begin failures++; $display("FAIL parity_slot_flags got_err=%0d exp=0", r_err); end
        $display("test_parity_frame strobes=%0d finish_at=%0d", r_strobes, r_finish_at);
    endtask

    task automatic test_enable_drop();
        idle_all();
        run_frame(0, 52, 5, 1'b0);
        checks++;
        if (r_strobe_cyc[3] !== 61) begin failures++; $display("FAIL drop_4th_strobe got=%0d exp=61", r_strobe_cyc[3]); end
        checks++;
        if (r_strobe_cyc[2] !== 40) begin failures++; $display("FAIL drop_3rd_strobe got=%0d exp=40", r_strobe_cyc[2]); end
        checks++;
        if (r_finish_at !== 166) begin failures++; $display("FAIL drop_finish_cycle got=%0d exp=166", r_finish_at); end
        checks++;
        if (r_strobes !== 10 || r_err !== 0) begin
            failures++; $display("FAIL drop_strobes_freeze strobes=%0d err=%0d exp strobes=10 err=0", r_strobes, r_err);
        end
        $display("test_enable_drop finish_at=%0d", r_finish_at);
    endtask

    task automatic test_clear();
        bit found;
        int nfin;
        idle_all();
        start = 1'b1; enable = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (st[0] === 4'd4) begin found = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!found) begin failures++; $display("FAIL clear_reach_state4 got=0 exp=1"); end
        clear = 1'b1; start = 1'b1;
        @(negedge clk);
        clear = 1'b0; start = 1'b0;
        #1;
        checks++;
        if (busy[0] !== 1'b0 || st[0] !== 4'd0 || finish[0] !== 1'b0) begin
            failures++; $display("FAIL clear_to_idle busy=%b state=%0d finish=%b exp 0/0/0", busy[0], st[0], finish[0]);
        end
        nfin = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (finish[0] === 1'b1 || busy[0] === 1'b1) nfin++;
        end
        checks++;
        if (nfin !== 0) begin failures++; $display("FAIL clear_no_finish got=%0d exp=0", nfin); end
        run_frame(0, 0, 0, 1'b0);
        checks++;
        if (r_finish_at !== 161 || r_strobes !== 10) begin
            failures++; $display("FAIL clear_next_frame finish_at=%0d strobes=%0d exp 161/10", r_finish_at, r_strobes);
        end
        $display("test_clear next_finish_at=%0d", r_finish_at);
    endtask

    task automatic test_reset_mid_frame();
        bit found;
        int nfin;
        idle_all();
        start = 1'b1; enable = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (st[0] === 4'd6) begin found = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!found) begin failures++; $display("FAIL reset_reach_state6 got=0 exp=1"); end
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy[0], sample_strobe[0], st[0], data_slot[0], parity_slot[0],
             stop_slot[0], finish[0]} !== 10'd0) begin
            failures++;
            $display("FAIL async_reset_outputs got=%b exp=0",
                     {busy[0], sample_strobe[0], st[0], data_slot[0], parity_slot[0],
                      stop_slot[0], finish[0]});
        end
        @(negedge clk);
        rst_n = 1'b1;
        nfin = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (finish[0] === 1'b1 || busy[0] === 1'b1) nfin++;
        end
        checks++;
        if (nfin !== 0) begin failures++; $display("FAIL reset_no_finish got=%0d exp=0", nfin); end
        run_frame(0, 0, 0, 1'b1);
        checks++;
        if (r_nfin !== 1 || r_finish_at !== 161) begin
            failures++; $display("FAIL start_in_done_ignored nfin=%0d finish_at=%0d exp 1/161", r_nfin, r_finish_at);
        end
        checks++;
        if (busy[0] !== 1'b0) begin failures++; $display("FAIL busy_after_done got=%b exp=0", busy[0]); end
        $display("test_reset_mid_frame nfin=%0d", r_nfin);
    endtask

    task automatic test_small_oversample();
        idle_all();
        run_frame(2, 0, 0, 1'b0);
        checks++;
        if (r_strobes !== 7) begin failures++; $display("FAIL os4_strobes got=%0d exp=7", r_strobes); end
        checks++;
        if (r_finish_at !== 29) begin failures++; $display("FAIL os4_finish_cycle got=%0d exp=29", r_finish_at); end
        checks++;
        if (r_strobe_cyc[0] !== 2 || r_strobe_cyc[1] !== 6) begin
            failures++; $display("FAIL os4_strobe_cycles got=%0d,%0d exp=2,6", r_strobe_cyc[0], r_strobe_cyc[1]);
        end
        checks++;
        if (r_err !== 0) begin failures++; $display("FAIL os4_slot_flags got_err=%0d exp=0", r_err); end
        $display("test_small_oversample strobes=%0d finish_at=%0d", r_strobes, r_finish_at);
    endtask

    initial begin
        test_reset();
        test_default_frame();
        test_parity_frame();
        test_enable_drop();
        test_clear();
        test_reset_mid_frame();
        test_small_oversample();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
